// File: rtl/pwm_dac_pkg.sv
// Shared constants for the multi-channel PWM DAC.
// The output mode is latched once per window so each window is fully edge- or center-aligned.
package pwm_dac_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock frame buffer with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       in_data,
    output logic [WIDTH-1:0]       out_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (PTR_W + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign out_data = mem[rd_ptr];

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: frames of codes are buffered and taken at window boundaries,
// each channel compares the shared window counter against its active code.
module pwm_dac_multi
    import pwm_dac_pkg::*;
#(
    parameter int NUM_CHANNELS      = 2,
    parameter int CYCLES_PER_WINDOW = 1024,
    parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW) + 1,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               center_mode,
    input  logic [NUM_CHANNELS*CODE_WIDTH-1:0] in_codes,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               clear_underrun,
    output logic [NUM_CHANNELS-1:0]            pwm,
    output logic                               next_sample,
    output logic                               underrun,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

    localparam int CNT_W   = $clog2(CYCLES_PER_WINDOW);
    localparam int FRAME_W = NUM_CHANNELS * CODE_WIDTH;
    // Wide enough for the clamped code and for lo + c, whichever code width is chosen.
    localparam int CMP_W   = (CODE_WIDTH + 1 > CNT_W + 2) ? CODE_WIDTH + 1 : CNT_W + 2;
    localparam logic [CMP_W-1:0] WIN  = CMP_W'(CYCLES_PER_WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_WINDOW - 1);

    if (CYCLES_PER_WINDOW < 4) begin : g_bad_window
        $error("CYCLES_PER_WINDOW must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [CNT_W-1:0]        counter;
    logic [CMP_W-1:0]        cnt_ext;
    logic                    boundary;
    pwm_mode_t               mode;
    logic [CODE_WIDTH-1:0]   bank [NUM_CHANNELS];
    logic [FRAME_W-1:0]      head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [NUM_CHANNELS-1:0] pwm_next;

    assign boundary    = enable && (counter == LAST);
    assign next_sample = boundary && rst_n;
    assign in_ready    = !fifo_full && rst_n;
    assign push        = in_valid && in_ready;
    assign pop         = next_sample && !fifo_empty;
    assign cnt_ext     = CMP_W'(counter);

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .in_data  (in_codes),
        .out_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (enable) begin
            counter <= boundary ? '0 : counter + 1'b1;
        end
    end

    // Codes and mode change only on the edge that closes a window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode <= pwm_mode_t'(center_mode);
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                bank[k] <= '0;
            end
        end else if (boundary) begin
            mode <= pwm_mode_t'(center_mode);
            if (!fifo_empty) begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    bank[k] <= head[k*CODE_WIDTH +: CODE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (boundary && fifo_empty) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        logic [CMP_W-1:0] code_ext;
        logic [CMP_W-1:0] eff;
        logic [CMP_W-1:0] lo;
        logic [CMP_W-1:0] hi;

        assign code_ext    = CMP_W'(bank[k]);
        assign eff         = (code_ext > WIN) ? WIN : code_ext;
        assign lo          = (WIN - eff) >> 1;
        assign hi          = lo + eff;
        assign pwm_next[k] = (mode == MODE_CENTER) ? ((cnt_ext >= lo) && (cnt_ext < hi))
                                                   : (cnt_ext < eff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm <= '0;
        end else begin
            pwm <= enable ? pwm_next : '0;
        end
    end

endmodule
